// File: rtl/pilha_ctrl.sv
// pilha_ctrl -- operand stack controller.
//
// Serializes push / pop / peek / replace-top requests arriving over a
// four-phase req/ack handshake, keeps the stack pointer and full/empty
// flags, and drives a single-port synchronous stack RAM (1-cycle read).
// Out-of-range accesses are rejected here, so the RAM is never written
// outside 0..DEPTH-1.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req, op, wdata      request level, opcode (00 push, 01 pop, 10 peek,
//                       11 replace-top), push/replace data
//   ack, err            completion (held until req drops), rejection flag
//   rdata               registered top-of-stack value from pop/peek/replace
//   count, full, empty  occupancy, 0..DEPTH
//   ovf_sticky          set by any rejected push, cleared only by reset
//   unf_sticky          set by any rejected pop/peek/replace
//   mem_addr, mem_wdata, mem_wren, mem_rdata   stack RAM port
module pilha_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b11;

  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_RD,
    S_RD_WAIT,
    S_WR_TOP,
    S_ACK
  } state_t;

  state_t            state, state_d;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rej_ovf, rej_unf;
  logic [ADDR_W:0]   count_m1;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign count_m1 = count - ONE;

  // ack/err are Moore outputs, so both fall in the cycle IDLE is re-entered.
  assign ack = (state == S_ACK);
  assign err = (state == S_ACK) && err_q;

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---- next state, rejection decision and RAM port decode ----
  always_comb begin
    state_d   = state;
    rej_ovf   = 1'b0;
    rej_unf   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (op == OP_PUSH) begin
            if (full) begin
              rej_ovf = 1'b1;
              state_d = S_ACK;
            end else begin
              state_d = S_PUSH;
            end
          end else begin
            if (empty) begin
              rej_unf = 1'b1;
              state_d = S_ACK;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_PUSH: begin
        // count < DEPTH here, so its low bits are the next free slot.
        mem_addr  = count[ADDR_W-1:0];
        mem_wdata = wdata_q;
        mem_wren  = 1'b1;
        state_d   = S_ACK;
      end
      S_RD: begin
        mem_addr = count_m1[ADDR_W-1:0];
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_addr = count_m1[ADDR_W-1:0];
        state_d  = (op_q == OP_REPL) ? S_WR_TOP : S_ACK;
      end
      S_WR_TOP: begin
        mem_addr  = count_m1[ADDR_W-1:0];
        mem_wdata = wdata_q;
        mem_wren  = 1'b1;
        state_d   = S_ACK;
      end
      S_ACK: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- request capture (data only, no reset needed) ----
  always_ff @(posedge clock) begin
    if (state == S_IDLE && req) begin
      op_q    <= op;
      wdata_q <= wdata;
    end
  end

  // ---- pointer, read data and status flags ----
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      rdata      <= '0;
      err_q      <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (state == S_IDLE && req) err_q <= rej_ovf | rej_unf;
      if (rej_ovf) ovf_sticky <= 1'b1;
      if (rej_unf) unf_sticky <= 1'b1;
      if (state == S_PUSH) count <= count + ONE;
      if (state == S_RD_WAIT) begin
        rdata <= mem_rdata;
        if (op_q == OP_POP) count <= count_m1;
      end
    end
  end

endmodule

// File: tb/tb_pilha_ctrl.sv
// Directed bench for pilha_ctrl with a behavioural 32x8 synchronous RAM.
module tb_pilha_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic [1:0] op;
  logic [7:0] wdata;
  logic       ack, err;
  logic [7:0] rdata;
  logic [5:0] count;
  logic       full, empty, ovf_sticky, unf_sticky;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wren;
  logic [7:0] mem_rdata;

  logic [7:0] ram [32];
  int         wr_cnt = 0;
  logic [4:0] last_addr;
  logic [7:0] last_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pilha_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .count(count), .full(full),
    .empty(empty), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  // Stack RAM: write-enable port plus registered read.
  always @(posedge clock) begin
    if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_addr     <= mem_addr;
      last_data     <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One handshake: raise req, count edges until ack, optionally hold req
  // for extra cycles, then drop req and confirm ack falls.
  task automatic xact(input logic [1:0] o, input logic [7:0] d,
                      input int lat, input logic e, input int nwr,
                      input int hold);
    int n;
    int w0;
    w0    = wr_cnt;
    op    = o;
    wdata = d;
    req   = 1'b1;
    n     = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!ack && n < 20);
    check("latency", n, lat);
    check("err", int'(err), int'(e));
    for (int h = 0; h < hold; h++) begin
      op = 2'b00;
      @(posedge clock); #1;
      check("ack_hold", int'(ack), 1);
    end
    check("writes", wr_cnt - w0, nwr);
    req = 1'b0;
    @(posedge clock); #1;
    check("ack_drop", int'(ack), 0);
    check("err_drop", int'(err), 0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; op = 2'b00; wdata = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_wren", int'(mem_wren), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_empty", int'(empty), 1);
    reset = 1'b0;
    @(posedge clock); #1;

    xact(2'b00, 8'h12, 2, 1'b0, 1, 0);
    check("push1_addr", int'(last_addr), 0);
    check("push1_data", int'(last_data), 8'h12);
    xact(2'b00, 8'h34, 2, 1'b0, 1, 0);
    check("push2_addr", int'(last_addr), 1);
    check("push2_data", int'(last_data), 8'h34);
    check("count2", int'(count), 2);
    check("empty2", int'(empty), 0);

    xact(2'b01, 8'h00, 3, 1'b0, 0, 0);
    check("pop_rdata", int'(rdata), 8'h34);
    check("pop_count", int'(count), 1);
    xact(2'b10, 8'h00, 3, 1'b0, 0, 0);
    check("peek_rdata", int'(rdata), 8'h12);
    check("peek_count", int'(count), 1);

    xact(2'b11, 8'hAB, 4, 1'b0, 1, 0);
    check("repl_rdata", int'(rdata), 8'h12);
    check("repl_addr", int'(last_addr), 0);
    check("repl_data", int'(last_data), 8'hAB);
    check("repl_count", int'(count), 1);
    xact(2'b10, 8'h00, 3, 1'b0, 0, 0);
    check("peek2_rdata", int'(rdata), 8'hAB);

    xact(2'b01, 8'h00, 3, 1'b0, 0, 0);
    check("empty_again", int'(empty), 1);

    for (int i = 0; i < 32; i++) begin
      xact(2'b00, 8'(i), 2, 1'b0, 1, 0);
      check("fill_addr", int'(last_addr), i);
    end
    check("full", int'(full), 1);
    check("count32", int'(count), 32);
    xact(2'b00, 8'hFF, 1, 1'b1, 0, 0);
    check("ovf_sticky", int'(ovf_sticky), 1);
    check("ovf_count", int'(count), 32);
    check("unf_clear", int'(unf_sticky), 0);

    for (int i = 0; i < 32; i++) begin
      xact(2'b01, 8'h00, 3, 1'b0, 0, 0);
      check("drain_rdata", int'(rdata), 31 - i);
    end
    check("drain_empty", int'(empty), 1);
    xact(2'b01, 8'h00, 1, 1'b1, 0, 0);
    check("unf_sticky", int'(unf_sticky), 1);
    check("unf_rdata", int'(rdata), 0);
    check("ovf_kept", int'(ovf_sticky), 1);
    check("unf_count", int'(count), 0);

    // Request held past ack: no new operation may start.
    xact(2'b00, 8'h55, 2, 1'b0, 1, 3);
    check("hold_count", int'(count), 1);

    // Reset while a pop sits in RD_WAIT.
    op = 2'b01; wdata = 8'h00; req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1; req = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_ack", int'(ack), 0);
    check("rst_mid_ovf", int'(ovf_sticky), 0);
    check("rst_mid_unf", int'(unf_sticky), 0);
    check("rst_mid_wren", int'(mem_wren), 0);
    check("rst_mid_rdata", int'(rdata), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_idle_ack", int'(ack), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
